// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port (WE3/A3/WD3).
// Define WB_FIXED_PRIO_EN for fixed priority 1 > 0 > 2 instead of round-robin.
module regfile_wb_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          STALL,
  input  logic [2:0]    REQ,
  input  logic [AW-1:0] A0,
  input  logic [AW-1:0] A1,
  input  logic [AW-1:0] A2,
  input  logic [DW-1:0] WD0,
  input  logic [DW-1:0] WD1,
  input  logic [DW-1:0] WD2,
  output logic [2:0]    GNT,
  output logic          WE3,
  output logic [AW-1:0] A3,
  output logic [DW-1:0] WD3,
  output logic          BUSY,
  output logic [7:0]    DROP_CNT
);

  typedef enum logic {IDLE, WRITE} st_t;

  st_t           st_q, st_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [DW-1:0] wd3_q, wd3_d;
  logic [7:0]    drop_q, drop_d;
  logic [2:0]    gnt;
  logic [AW-1:0] ga;
  logic [DW-1:0] gwd;

`ifndef WB_FIXED_PRIO_EN
  logic [5:0] rot2;
  logic [2:0] rot;
  logic [2:0] hit;
  logic [5:0] back;
`endif

  // Rotate so PTR sits at bit 0, take lowest set bit, rotate back.
  always_comb begin
    gnt = '0;
`ifdef WB_FIXED_PRIO_EN
    if (REQ[1])      gnt = 3'b010;
    else if (REQ[0]) gnt = 3'b001;
    else if (REQ[2]) gnt = 3'b100;
`else
    rot2 = {REQ, REQ} >> ptr_q;
    rot  = rot2[2:0];
    hit  = rot & (~rot + 3'd1);
    back = {hit, hit} << ptr_q;
    gnt  = back[5:3];
`endif
    if (!RST_N || STALL) gnt = '0;
  end

  always_comb begin
    ga  = '0;
    gwd = '0;
    unique case (1'b1)
      gnt[0]: begin ga = A0; gwd = WD0; end
      gnt[1]: begin ga = A1; gwd = WD1; end
      gnt[2]: begin ga = A2; gwd = WD2; end
      default: ;
    endcase
  end

  always_comb begin
    st_d   = IDLE;
    ptr_d  = ptr_q;
    a3_d   = a3_q;
    wd3_d  = wd3_q;
    drop_d = drop_q;
    if (|gnt) begin
      unique case (1'b1)
        gnt[0]:  ptr_d = 2'd1;
        gnt[1]:  ptr_d = 2'd2;
        default: ptr_d = 2'd0;
      endcase
      if (ga != '0) begin
        st_d  = WRITE;
        a3_d  = ga;
        wd3_d = gwd;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
`ifdef WB_FIXED_PRIO_EN
    ptr_d = 2'd0;
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      st_q   <= IDLE;
      ptr_q  <= 2'd0;
      a3_q   <= '0;
      wd3_q  <= '0;
      drop_q <= '0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      drop_q <= drop_d;
    end
  end

  assign GNT      = gnt;
  assign WE3      = (st_q == WRITE);
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign BUSY     = |(REQ & ~gnt);
  assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-cycle model compare
// plus directed literal checks.
module tb_regfile_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        STALL;
  logic [2:0]  REQ;
  logic [4:0]  A0, A1, A2;
  logic [31:0] WD0, WD1, WD2;
  logic [2:0]  GNT;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        BUSY;
  logic [7:0]  DROP_CNT;

  int tests = 0;
  int fails = 0;
  bit en = 1'b0;

  // model state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_a;
  logic [31:0] m_wd;
  int          m_drop;

  regfile_wb_arbiter #(.AW(5), .DW(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .REQ(REQ),
    .A0(A0), .A1(A1), .A2(A2),
    .WD0(WD0), .WD1(WD1), .WD2(WD2),
    .GNT(GNT), .WE3(WE3), .A3(A3), .WD3(WD3),
    .BUSY(BUSY), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic int mgrant();
    int k;
    if (!RST_N || STALL) return -1;
    for (int i = 0; i < 3; i++) begin
`ifdef WB_FIXED_PRIO_EN
      k = (i == 0) ? 1 : (i == 1) ? 0 : 2;
`else
      k = (m_ptr + i) % 3;
`endif
      if (REQ[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [4:0] addr_of(input int k);
    return (k == 0) ? A0 : (k == 1) ? A1 : A2;
  endfunction

  function automatic logic [31:0] data_of(input int k);
    return (k == 0) ? WD0 : (k == 1) ? WD1 : WD2;
  endfunction

  always @(posedge CLK) begin
    int g;
    g = mgrant();
    if (!RST_N) begin
      m_ptr  <= 0;
      m_we   <= 1'b0;
      m_a    <= '0;
      m_wd   <= '0;
      m_drop <= 0;
    end else begin
      m_we <= 1'b0;
      if (g >= 0) begin
`ifndef WB_FIXED_PRIO_EN
        m_ptr <= (g + 1) % 3;
`endif
        if (addr_of(g) != 0) begin
          m_we <= 1'b1;
          m_a  <= addr_of(g);
          m_wd <= data_of(g);
        end else if (m_drop < 255) begin
          m_drop <= m_drop + 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    int g;
    logic [2:0] eg;
    if (en) begin
      g  = mgrant();
      eg = (g < 0) ? 3'b000 : 3'(1 << g);
      check("m_gnt", 64'(GNT), 64'(eg));
      check("m_busy", 64'(BUSY), 64'(|(REQ & ~eg)));
      check("m_we3", 64'(WE3), 64'(m_we));
      check("m_a3", 64'(A3), 64'(m_a));
      check("m_wd3", 64'(WD3), 64'(m_wd));
      check("m_drop", 64'(DROP_CNT), 64'(m_drop));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; STALL = 1'b0; REQ = '0;
    A0 = '0; A1 = '0; A2 = '0;
    WD0 = '0; WD1 = '0; WD2 = '0;
    cyc();
    en = 1'b1;
    REQ = 3'b111;
    @(negedge CLK);
    check("rst_gnt", 64'(GNT), 64'h0);
    check("rst_we3", 64'(WE3), 64'h0);
    check("rst_drop", 64'(DROP_CNT), 64'h0);
    check("rst_a3", 64'(A3), 64'h0);
    cyc();

    // single request
    RST_N = 1'b1;
    REQ = 3'b001; A0 = 5'd8; WD0 = 32'hDEADBEEF;
    @(negedge CLK);
    check("single_gnt", 64'(GNT), 64'h1);
    cyc();
    REQ = '0;
    @(negedge CLK);
    check("single_we3", 64'(WE3), 64'h1);
    check("single_a3", 64'(A3), 64'd8);
    check("single_wd3", 64'(WD3), 64'hDEADBEEF);
    cyc();
    @(negedge CLK);
    check("single_we3_off", 64'(WE3), 64'h0);
    check("single_a3_hold", 64'(A3), 64'd8);

    // all three from PTR=0
    RST_N = 1'b0;
    cyc();
    RST_N = 1'b1;
    A0 = 5'd1; A1 = 5'd2; A2 = 5'd3;
    WD0 = 32'h100; WD1 = 32'h101; WD2 = 32'h102;
    REQ = 3'b111;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("all_busy", 64'(BUSY), 64'h1);
`ifndef WB_FIXED_PRIO_EN
      check("all_gnt", 64'(GNT), 64'(1 << (i % 3)));
      if (i > 0) begin
        check("all_we3", 64'(WE3), 64'h1);
        check("all_a3", 64'(A3), 64'((i - 1) % 3 + 1));
      end
`endif
      cyc();
    end
    REQ = 3'b001;
    @(negedge CLK);
    check("one_left_busy", 64'(BUSY), 64'h0);
    cyc();

    // writes to r0
    REQ = 3'b100; A2 = 5'd0;
    @(negedge CLK);
    check("r0_gnt", 64'(GNT), 64'h4);
    cyc();
    @(negedge CLK);
    check("r0_we3", 64'(WE3), 64'h0);
    check("r0_drop1", 64'(DROP_CNT), 64'd1);
    for (int i = 1; i < 300; i++) cyc();
    REQ = '0;
    @(negedge CLK);
    check("r0_sat", 64'(DROP_CNT), 64'd255);
    cyc();

    // stall
    STALL = 1'b1; REQ = 3'b011;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("stall_gnt", 64'(GNT), 64'h0);
      check("stall_busy", 64'(BUSY), 64'h1);
      cyc();
    end
    STALL = 1'b0;
    @(negedge CLK);
`ifndef WB_FIXED_PRIO_EN
    check("unstall_first", 64'(GNT), 64'h1);
`else
    check("unstall_first", 64'(GNT), 64'h2);
`endif
    cyc();
    @(negedge CLK);
`ifndef WB_FIXED_PRIO_EN
    check("unstall_second", 64'(GNT), 64'h2);
`else
    check("unstall_second", 64'(GNT), 64'h2);
`endif
    cyc();
    REQ = '0;
    cyc();

    // same destination, serialized
    REQ = 3'b011; A0 = 5'd9; A1 = 5'd9;
    WD0 = 32'hAAAA0000; WD1 = 32'hBBBB1111;
    cyc();
    cyc();
    REQ = '0;
    @(negedge CLK);
    check("same_dst_a3", 64'(A3), 64'd9);
    cyc();

    // reset after grant
    REQ = 3'b010; A1 = 5'd31; WD1 = 32'h31313131;
    @(negedge CLK);
    check("rstmid_gnt", 64'(GNT), 64'h2);
    cyc();
    REQ = 3'b010; RST_N = 1'b0;
    @(negedge CLK);
    check("rstmid_gnt0", 64'(GNT), 64'h0);
    check("rstmid_we3", 64'(WE3), 64'h1);
    check("rstmid_a3", 64'(A3), 64'd31);
    cyc();
    @(negedge CLK);
    check("rstmid_we3_off", 64'(WE3), 64'h0);
    check("rstmid_drop", 64'(DROP_CNT), 64'h0);
    RST_N = 1'b1;
    REQ = 3'b111;
    A0 = 5'd4; A1 = 5'd5; A2 = 5'd6;
    #1;
`ifndef WB_FIXED_PRIO_EN
    check("rstmid_ptr0", 64'(GNT), 64'h1);
`else
    check("rstmid_ptr0", 64'(GNT), 64'h2);
`endif
    cyc();

    // fixed priority: port 1 starves the others
`ifdef WB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("fixed_p1", 64'(GNT), 64'h2);
      cyc();
    end
    REQ = 3'b101;
    @(negedge CLK);
    check("fixed_p0", 64'(GNT), 64'h1);
`else
    for (int i = 0; i < 4; i++) cyc();
`endif
    cyc();
    REQ = '0;
    cyc();
    cyc();
    en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
